// File: rtl/rr_mux_arbiter8.sv
// rr_mux_arbiter8: round-robin arbiter sharing one 8:1 lookup mux between
// eight requesters. A winner keeps the mux until it releases it or drops its
// request; every grant is followed by at least one idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN (forces a release after HOLD_LIMIT
// cycles in GRANT and pulses io_timeout). Without it io_timeout is tied to 0.
module rr_mux_arbiter8 #(
  parameter int HOLD_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       io_req,
  input  logic             io_release,
  output logic [7:0]       io_grant,
  output logic [2:0]       io_sel,
  output logic             io_busy,
  output logic             io_timeout,
  output logic [CNT_W-1:0] io_grant_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_reg,  state_next;
  logic [2:0]       ptr_reg,    ptr_next;
  logic [7:0]       grant_reg,  grant_next;
  logic [2:0]       sel_reg,    sel_next;
  logic             busy_reg,   busy_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;

  // Scan order: candidate gi is the requester (gi+1) places after the last winner.
  logic [2:0] scan_idx [8];
  logic [7:0] scan_hit;
  logic       win_found;
  logic [2:0] win_idx;

  logic release_cond;
  logic force_release;
  logic take_grant;
  logic drop_grant;

  // Marker scope that only elaborates when HOLD_LIMIT is outside 2..255.
  if (HOLD_LIMIT < 2 || HOLD_LIMIT > 255) begin : g_hold_limit_out_of_range
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_scan
    assign scan_idx[gi] = ptr_reg + 3'(gi + 1);
    assign scan_hit[gi] = io_req[scan_idx[gi]];
  end

  // Pick the nearest requesting candidate after the pointer (lowest scan slot wins).
  always_comb begin
    win_found = |scan_hit;
    win_idx   = ptr_reg;
    for (int i = 7; i >= 0; i--) begin
      if (scan_hit[i]) begin
        win_idx = scan_idx[i];
      end
    end
  end

  // While granted, ptr_reg is the owner, so its request bit tells whether it still wants the mux.
  assign release_cond = io_release | ~io_req[ptr_reg];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);

  logic [7:0] hold_reg, hold_next;
  logic       timeout_reg, timeout_next;

  // A normal release on the limit cycle wins, so the timeout only fires when the owner holds on.
  assign force_release = (state_reg == GRANT) && !release_cond && (hold_reg == HOLD_LAST);

  // Hold counter restarts with each new grant and counts cycles spent in GRANT.
  always_comb begin
    hold_next    = hold_reg;
    timeout_next = force_release;
    if (take_grant) begin
      hold_next = 8'd0;
    end else if (state_reg == GRANT) begin
      hold_next = hold_reg + 8'd1;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg    <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  assign io_timeout = timeout_reg;
`else
  assign force_release = 1'b0;
  assign io_timeout    = 1'b0;
`endif

  // State register plus all registered outputs; reset parks the pointer at 7 so index 0 is scanned first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd7;
      grant_reg <= 8'd0;
      sel_reg   <= 3'd0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: every grant ends by returning to IDLE, so grants are never back-to-back.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_cond || force_release) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign take_grant = (state_reg == IDLE) && win_found;
  assign drop_grant = (state_reg == GRANT) && (state_next == IDLE);

  // Output logic: load the winner on grant entry, clear grant/busy on drop; io_sel always holds.
  always_comb begin
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;
    if (take_grant) begin
      grant_next = 8'd1 << win_idx;
      sel_next   = win_idx;
      ptr_next   = win_idx;
      busy_next  = 1'b1;
      if (cnt_reg != {CNT_W{1'b1}}) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (drop_grant) begin
      grant_next = 8'd0;
      busy_next  = 1'b0;
    end
  end

  assign io_grant     = grant_reg;
  assign io_sel       = sel_reg;
  assign io_busy      = busy_reg;
  assign io_grant_cnt = cnt_reg;

endmodule

// File: tb/tb_rr_mux_arbiter8.sv
// Testbench for rr_mux_arbiter8: directed scenarios plus random traffic,
// every cycle compared against a behavioural round-robin model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_rr_mux_arbiter8;

  localparam int HOLD_LIMIT = 16;
  localparam int CNT_W      = 4;   // narrow so saturation is reached
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       io_req = 8'd0;
  logic             io_release = 1'b0;
  logic [7:0]       io_grant;
  logic [2:0]       io_sel;
  logic             io_busy;
  logic             io_timeout;
  logic [CNT_W-1:0] io_grant_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs must be after the most recent edge.
  int m_busy, m_owner, m_last, m_sel, m_cnt, m_hold, m_to;

  rr_mux_arbiter8 #(.HOLD_LIMIT(HOLD_LIMIT), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_req      (io_req),
    .io_release  (io_release),
    .io_grant    (io_grant),
    .io_sel      (io_sel),
    .io_busy     (io_busy),
    .io_timeout  (io_timeout),
    .io_grant_cnt(io_grant_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requester found walking forward from the one after 'last', wrapping mod 8.
  function automatic int pick(input int last, input logic [7:0] req);
    for (int k = 1; k <= 8; k++) begin
      if (req[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst, input logic [7:0] req, input logic rel);
    int w;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 7; m_sel = 0; m_cnt = 0; m_hold = 0; m_to = 0;
    end else if (m_busy == 0) begin
      m_to = 0;
      w = pick(m_last, req);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_sel = w; m_hold = 0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end else begin
      m_to = 0;
      if (rel || !req[m_owner]) begin
        m_busy = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_hold == HOLD_LIMIT - 1) begin
          m_busy = 0;
          m_to   = 1;
        end else begin
          m_hold = m_hold + 1;
        end
`endif
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model, compare just after the rising edge.
  task automatic step(input logic rst, input logic [7:0] req, input logic rel);
    logic [7:0] exp_grant;
    @(negedge clock);
    reset      = rst;
    io_req     = req;
    io_release = rel;
    model_edge(rst, req, rel);
    @(posedge clock);
    #1;
    exp_grant = (m_busy != 0) ? (8'd1 << m_owner) : 8'd0;
    $display("t=%0t rst=%0b req=%02h rel=%0b -> grant=%02h sel=%0d busy=%0b to=%0b cnt=%0d",
             $time, rst, req, rel, io_grant, io_sel, io_busy, io_timeout, io_grant_cnt);
    chk("grant",   32'(io_grant),     32'(exp_grant));
    chk("sel",     32'(io_sel),       32'(m_sel));
    chk("busy",    32'(io_busy),      32'(m_busy));
    chk("timeout", 32'(io_timeout),   32'(m_to));
    chk("cnt",     32'(io_grant_cnt), 32'(m_cnt));
  endtask

  initial begin
    int g5, to20, other;
    logic [7:0] rq;
    logic [7:0] prev_grant;

    // Reset, then 0x81: grant 0, release, idle, grant 7, release, idle, grant 0 again.
    step(1'b1, 8'h00, 1'b0);
    chk("rst_grant", 32'(io_grant), 32'h0);
    chk("rst_cnt",   32'(io_grant_cnt), 32'h0);
    step(1'b0, 8'h81, 1'b0);
    chk("tp1_grant0", 32'(io_grant), 32'h01);
    step(1'b0, 8'h81, 1'b1);
    step(1'b0, 8'h81, 1'b0);
    chk("tp1_grant7", 32'(io_grant), 32'h80);
    chk("tp1_sel7",   32'(io_sel),   32'd7);
    step(1'b0, 8'h81, 1'b1);
    step(1'b0, 8'h81, 1'b0);
    chk("tp1_wrap",  32'(io_grant),     32'h01);
    chk("tp1_cnt3",  32'(io_grant_cnt), 32'd3);

    // All requesting, releasing each grant: winners walk 1..7,0,1.
    step(1'b0, 8'hFF, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 8'hFF, 1'b0);
      chk("rr_order", 32'(io_sel), 32'(i % 8));
      step(1'b0, 8'hFF, 1'b1);
      chk("rr_gap", 32'(io_grant), 32'h0);
    end

    // Owner 3 drops its request: grant falls, next winner is 4.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    chk("drop_g3", 32'(io_grant), 32'h08);
    step(1'b0, 8'h30, 1'b0);
    chk("drop_idle", 32'(io_busy), 32'd0);
    step(1'b0, 8'h30, 1'b0);
    chk("drop_next4", 32'(io_grant), 32'h10);

    // Owner 5 holds with everyone requesting for 40 cycles.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    g5 = 0; to20 = 0; other = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'hFF, 1'b0);
      if (io_grant == 8'h20) g5++;
      if (i < 20 && io_timeout) to20++;
      if (other < 0 && io_grant != 8'h00 && io_grant != 8'h20) other = int'(io_sel);
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_len",   32'(g5),    32'(HOLD_LIMIT - 1));
    chk("hold_to",    32'(to20),  32'd1);
    chk("hold_next6", 32'(other), 32'd6);
`else
    chk("hold_len",   32'(g5),    32'd40);
    chk("hold_to",    32'(to20),  32'd0);
    chk("hold_sel5",  32'(io_sel), 32'd5);
`endif

    // Reset while owner 2 holds, then re-request 2.
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    chk("midrst_grant", 32'(io_grant), 32'h0);
    step(1'b0, 8'h04, 1'b0);
    chk("midrst_g2",  32'(io_grant),     32'h04);
    chk("midrst_cnt", 32'(io_grant_cnt), 32'd1);

    // Random traffic: sticky requests, occasional release and reset.
    rq = 8'($urandom);
    prev_grant = io_grant;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom);
      step(($urandom_range(0, 399) == 0), rq, ($urandom_range(0, 5) == 0));
      if (prev_grant != 8'h00 && io_grant != 8'h00) begin
        chk("no_b2b_same", 32'(io_grant), 32'(prev_grant));
      end
      prev_grant = io_grant;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
